imem_access_arbiter: RTL

- Sole owner of the instruction memory's single write port and single asynchronous read port.
- Shares the memory between two requesters:
  - the fetch unit: byte-addressed reads, one outstanding, registered response with backpressure;
  - the program loader/debug port: word writes.
- Arbitrates round-robin on conflict, range-checks fetch addresses and supports fetch flush.

---
 rtl/imem_access_arbiter_if.sv | 39 +++
 rtl/imem_access_arbiter.sv | 88 ++++++++
 2 files changed

// File: rtl/imem_access_arbiter_if.sv
// Bundle of fetch, loader and instruction-memory signals shared by the arbiter.
// The arbiter takes the slave view; requesters and the memory model take the master view.
interface imem_access_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH   = 32
);
  logic                  if_req_valid;
  logic                  if_req_ready;
  logic [PC_WIDTH-1:0]   if_req_pc;
  logic                  if_flush;
  logic                  if_rsp_valid;
  logic                  if_rsp_ready;
  logic [DATA_WIDTH-1:0] if_rsp_data;
  logic                  if_rsp_err;
  logic                  ld_valid;
  logic                  ld_ready;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic [DATA_WIDTH-1:0] ld_data;
  logic [ADDR_WIDTH-1:0] mem_raddr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_wen;

  modport slave (
    input  if_req_valid, if_req_pc, if_flush, if_rsp_ready,
    input  ld_valid, ld_addr, ld_data, mem_rdata,
    output if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
    output ld_ready, mem_raddr, mem_waddr, mem_wdata, mem_wen
  );

  modport master (
    output if_req_valid, if_req_pc, if_flush, if_rsp_ready,
    output ld_valid, ld_addr, ld_data, mem_rdata,
    input  if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
    input  ld_ready, mem_raddr, mem_waddr, mem_wdata, mem_wen
  );
endinterface

// File: rtl/imem_access_arbiter.sv
// Owns the instruction memory ports: round-robin between fetch reads and loader writes,
// with a registered fetch response, address range check and flush.
module imem_access_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH   = 32,
  parameter int ADDR_LSB   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  imem_access_arbiter_if.slave bus
);
  localparam int IDX_TOP = ADDR_LSB + ADDR_WIDTH;

  typedef enum logic {ST_IDLE = 1'b0, ST_RESP = 1'b1} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_last_grant;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic                  r_rsp_err;
  logic [ADDR_WIDTH-1:0] r_raddr;

  logic                  w_fe;
  logic                  w_grant_f;
  logic                  w_grant_l;
  logic                  w_oob;
  logic [ADDR_WIDTH-1:0] w_idx;

  assign w_idx = bus.if_req_pc[ADDR_LSB +: ADDR_WIDTH];

  generate
    if (PC_WIDTH > IDX_TOP) begin : g_range
      assign w_oob = |bus.if_req_pc[PC_WIDTH-1:IDX_TOP];
    end else begin : g_no_range
      assign w_oob = 1'b0;
    end
    if (ADDR_LSB > 0) begin : g_lsb
      logic w_unused_lsb;
      assign w_unused_lsb = ^bus.if_req_pc[ADDR_LSB-1:0];
    end
  endgenerate

  always_comb begin
    w_state_next     = r_state;
    w_fe             = (r_state == ST_IDLE) ||
                       (bus.if_rsp_ready && !bus.if_flush);
    // last grant 1 means the loader won last, so fetch wins a conflict
    w_grant_f        = w_fe && bus.if_req_valid && (!bus.ld_valid || r_last_grant);
    w_grant_l        = bus.ld_valid && !w_grant_f;

    bus.if_req_ready = w_grant_f;
    bus.ld_ready     = w_grant_l;
    bus.mem_wen      = w_grant_l;
    bus.mem_waddr    = w_grant_l ? bus.ld_addr : '0;
    bus.mem_wdata    = w_grant_l ? bus.ld_data : '0;
    bus.mem_raddr    = w_grant_f ? w_idx : r_raddr;
    bus.if_rsp_valid = (r_state == ST_RESP);
    bus.if_rsp_data  = r_rsp_data;
    bus.if_rsp_err   = r_rsp_err;

    if (w_grant_f) begin
      w_state_next = ST_RESP;
    end else if (r_state == ST_RESP && (bus.if_flush || bus.if_rsp_ready)) begin
      w_state_next = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_rsp_data   <= '0;
      r_rsp_err    <= 1'b0;
      r_raddr      <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_grant_f) begin
        r_last_grant <= 1'b0;
        r_rsp_data   <= w_oob ? '0 : bus.mem_rdata;
        r_rsp_err    <= w_oob;
        r_raddr      <= w_idx;
      end else if (w_grant_l) begin
        r_last_grant <= 1'b1;
      end
    end
  end
endmodule
